// File: rtl/pipe_bus_pkg.sv
// Shared EX->ME and ME->WB bus layouts: widths, field offsets, flag bits.
// Also holds the small load-extension helpers used by the ME stage.
package pipe_bus_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    // dest_flag bit positions (inside the 5-bit flag field)
    localparam int FLAG_ADDR_LSB = 0;
    localparam int FLAG_HALF     = FLAG_ADDR_LSB + 2;
    localparam int FLAG_BYTE     = FLAG_HALF + 1;
    localparam int FLAG_SGN      = FLAG_BYTE + 1;
    localparam int FLAG_W        = FLAG_SGN + 1;

    // EX->ME bus field offsets
    localparam int EXME_DEST_LSB = 0;
    localparam int EXME_WE_BIT   = EXME_DEST_LSB + REG_W;
    localparam int EXME_MEM_BIT  = EXME_WE_BIT + 1;
    localparam int EXME_ALU_LSB  = EXME_MEM_BIT + 1;
    localparam int EXME_PC_LSB   = EXME_ALU_LSB + DATA_W;
    localparam int EXME_FLAG_LSB = EXME_PC_LSB + DATA_W;
    localparam int EX_ME_W       = EXME_FLAG_LSB + FLAG_W;

    // ME->WB bus field offsets
    localparam int MEWB_DEST_LSB = 0;
    localparam int MEWB_WE_BIT   = MEWB_DEST_LSB + REG_W;
    localparam int MEWB_RES_LSB  = MEWB_WE_BIT + 1;
    localparam int MEWB_PC_LSB   = MEWB_RES_LSB + DATA_W;
    localparam int ME_WB_W       = MEWB_PC_LSB + DATA_W;

    typedef struct packed {
        logic       sgn;
        logic       is_byte;
        logic       is_half;
        logic [1:0] addr;
    } dest_flag_t;

    typedef struct packed {
        dest_flag_t        flag;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] alu_result;
        logic              res_from_mem;
        logic              gr_we;
        logic [REG_W-1:0]  dest;
    } ex_me_t;

    typedef struct packed {
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] final_result;
        logic              gr_we;
        logic [REG_W-1:0]  dest;
    } me_wb_t;

    function automatic logic [DATA_W-1:0] ext_byte(
        input logic [7:0] b,
        input logic       sgn
    );
        return {{24{sgn & b[7]}}, b};
    endfunction

    function automatic logic [DATA_W-1:0] ext_half(
        input logic [15:0] h,
        input logic        sgn
    );
        return {{16{sgn & h[15]}}, h};
    endfunction

endpackage

// File: rtl/load_align.sv
// Load data alignment: picks byte/half/word lane from a 32-bit read word
// using the low address bits, then sign- or zero-extends.
module load_align
    import pipe_bus_pkg::*;
(
    input  logic [DATA_W-1:0] rdata,
    input  dest_flag_t        dest_flag,
    output logic [DATA_W-1:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[7:0];
        unique case (dest_flag.addr)
            2'd0: byte_sel = rdata[7:0];
            2'd1: byte_sel = rdata[15:8];
            2'd2: byte_sel = rdata[23:16];
            2'd3: byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
    end

    assign half_sel = dest_flag.addr[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        result = rdata;
        unique case (1'b1)
            dest_flag.is_byte: result = ext_byte(byte_sel, dest_flag.sgn);
            dest_flag.is_half: result = ext_half(half_sel, dest_flag.sgn);
            default:           result = rdata;
        endcase
    end

endmodule

// File: rtl/me_unit.sv
// Memory stage: latches EX payload, aligns load data, holds SRAM data on stall.
// Build option ME_LOAD_FWD_EN: forward aligned load data to ID instead of stalling.
module me_unit
    import pipe_bus_pkg::*;
(
    input  logic               clk,
    input  logic               resetn,
    input  logic               EX_to_ME_Valid,
    input  logic [EX_ME_W-1:0] EX_to_ME_Bus,
    output logic               ME_Allow_in,
    input  logic [DATA_W-1:0]  data_sram_rdata,
    input  logic               WB_Allow_in,
    output logic               ME_to_WB_Valid,
    output logic [ME_WB_W-1:0] ME_to_WB_Bus,
    output logic [REG_W-1:0]   ME_dest,
    output logic [DATA_W-1:0]  ME_Forward_Res,
    output logic               ME_to_ID_Ld_op
);

    logic              me_valid;
    ex_me_t            me_bus;
    logic              hold_vld;
    logic [DATA_W-1:0] hold_data;
    logic [DATA_W-1:0] ld_src;
    logic [DATA_W-1:0] ld_data;
    logic [DATA_W-1:0] final_result;
    me_wb_t            wb_bus;

    assign ME_Allow_in = !me_valid || WB_Allow_in;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            me_valid <= 1'b0;
        end else if (ME_Allow_in) begin
            me_valid <= EX_to_ME_Valid;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            me_bus <= '0;
        end else if (ME_Allow_in && EX_to_ME_Valid) begin
            me_bus <= ex_me_t'(EX_to_ME_Bus);
        end
    end

    // SRAM data is only valid in the first occupied cycle; keep it
    // if WB is not ready so a stall cannot lose it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hold_vld  <= 1'b0;
            hold_data <= '0;
        end else if (ME_Allow_in) begin
            hold_vld  <= 1'b0;
        end else if (!hold_vld) begin
            hold_vld  <= 1'b1;
            hold_data <= data_sram_rdata;
        end
    end

    assign ld_src = hold_vld ? hold_data : data_sram_rdata;

    load_align u_load_align (
        .rdata     (ld_src),
        .dest_flag (me_bus.flag),
        .result    (ld_data)
    );

    assign final_result = me_bus.res_from_mem ? ld_data
                                              : me_bus.alu_result;

    always_comb begin
        wb_bus              = '0;
        wb_bus.pc           = me_bus.pc;
        wb_bus.final_result = final_result;
        wb_bus.gr_we        = me_bus.gr_we;
        wb_bus.dest         = me_bus.dest;
    end

    assign ME_to_WB_Bus   = wb_bus;
    assign ME_to_WB_Valid = me_valid;
    assign ME_dest        = me_bus.dest & {REG_W{me_valid}};

`ifdef ME_LOAD_FWD_EN
    assign ME_Forward_Res = final_result;
    assign ME_to_ID_Ld_op = 1'b0;
`else
    assign ME_Forward_Res = me_bus.alu_result;
    assign ME_to_ID_Ld_op = me_valid && me_bus.res_from_mem;
`endif

endmodule

// File: tb/tb_me_unit.sv
// Self-checking bench for me_unit: directed load/stall/reset scenarios
// plus randomized traffic against a transaction-level reference model.
module tb_me_unit;

    logic        clk = 1'b0;
    logic        resetn;
    logic        EX_to_ME_Valid;
    logic [75:0] EX_to_ME_Bus;
    logic        ME_Allow_in;
    logic [31:0] data_sram_rdata;
    logic        WB_Allow_in;
    logic        ME_to_WB_Valid;
    logic [69:0] ME_to_WB_Bus;
    logic [4:0]  ME_dest;
    logic [31:0] ME_Forward_Res;
    logic        ME_to_ID_Ld_op;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef ME_LOAD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    always #5 clk = ~clk;

    me_unit dut (
        .clk             (clk),
        .resetn          (resetn),
        .EX_to_ME_Valid  (EX_to_ME_Valid),
        .EX_to_ME_Bus    (EX_to_ME_Bus),
        .ME_Allow_in     (ME_Allow_in),
        .data_sram_rdata (data_sram_rdata),
        .WB_Allow_in     (WB_Allow_in),
        .ME_to_WB_Valid  (ME_to_WB_Valid),
        .ME_to_WB_Bus    (ME_to_WB_Bus),
        .ME_dest         (ME_dest),
        .ME_Forward_Res  (ME_Forward_Res),
        .ME_to_ID_Ld_op  (ME_to_ID_Ld_op)
    );

    function automatic logic [75:0] mk_bus(
        input bit sgn, input bit byt, input bit half,
        input logic [1:0] addr, input logic [31:0] pc,
        input logic [31:0] alu, input bit rfm, input bit we,
        input logic [4:0] dest
    );
        return {sgn, byt, half, addr, pc, alu, rfm, we, dest};
    endfunction

    // Architectural load semantics with plain shifts and masks
    function automatic logic [31:0] ref_align(
        input logic [31:0] w, input bit sgn, input bit byt,
        input bit half, input int addr
    );
        logic [31:0] v;
        if (byt) begin
            v = (w >> (8 * addr)) & 32'hFF;
            if (sgn && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else if (half) begin
            v = (w >> (16 * (addr / 2))) & 32'hFFFF;
            if (sgn && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        EX_to_ME_Valid = 1'b1;
        EX_to_ME_Bus = mk_bus(1, 1, 0, 3, 32'h1111, 32'h2222, 1, 1, 9);
        WB_Allow_in = 1'b0;
        data_sram_rdata = 32'hFFFF_FFFF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (ME_to_WB_Valid !== 1'b0) begin n_bad++;
            $display("FAIL rst_valid: got %b want 0", ME_to_WB_Valid); end
        n_cmp++; if (ME_Allow_in !== 1'b1) begin n_bad++;
            $display("FAIL rst_allow: got %b want 1", ME_Allow_in); end
        n_cmp++; if (ME_to_WB_Bus !== 70'h0) begin n_bad++;
            $display("FAIL rst_bus: got %h want 0", ME_to_WB_Bus); end
        n_cmp++; if (ME_dest !== 5'd0) begin n_bad++;
            $display("FAIL rst_dest: got %0d want 0", ME_dest); end
        n_cmp++; if (ME_Forward_Res !== 32'h0) begin n_bad++;
            $display("FAIL rst_fwd: got %h want 0", ME_Forward_Res); end
        n_cmp++; if (ME_to_ID_Ld_op !== 1'b0) begin n_bad++;
            $display("FAIL rst_ldop: got %b want 0", ME_to_ID_Ld_op); end
        EX_to_ME_Valid = 1'b0;
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_ld_b_signed();
        logic [31:0] res;
        EX_to_ME_Valid = 1'b1;
        EX_to_ME_Bus = mk_bus(1, 1, 0, 3, 32'h0000_1000,
                              32'h1000_0003, 1, 1, 7);
        WB_Allow_in = 1'b1;
        tick();
        EX_to_ME_Valid = 1'b0;
        data_sram_rdata = 32'h80FF_1234;
        @(negedge clk);
        res = ME_to_WB_Bus[37:6];
        n_cmp++; if (ME_to_WB_Valid !== 1'b1) begin n_bad++;
            $display("FAIL ldb_valid: got %b want 1", ME_to_WB_Valid); end
        n_cmp++; if (res !== 32'hFFFF_FF80) begin n_bad++;
            $display("FAIL ldb_result: got %h want ffffff80", res); end
        n_cmp++; if (ME_to_WB_Bus[69:38] !== 32'h0000_1000) begin n_bad++;
            $display("FAIL ldb_pc: got %h want 1000", ME_to_WB_Bus[69:38]); end
        n_cmp++; if (ME_to_ID_Ld_op !== !FWD) begin n_bad++;
            $display("FAIL ldb_ldop: got %b want %b", ME_to_ID_Ld_op, !FWD); end
        n_cmp++;
        if (ME_Forward_Res !== (FWD ? 32'hFFFF_FF80 : 32'h1000_0003)) begin
            n_bad++;
            $display("FAIL ldb_fwd: got %h", ME_Forward_Res);
        end
        tick();
        @(negedge clk);
        n_cmp++; if (ME_to_WB_Valid !== 1'b0) begin n_bad++;
            $display("FAIL ldb_drain: got %b want 0", ME_to_WB_Valid); end
        tick();
    endtask

    task automatic test_ld_hu();
        logic [31:0] res;
        EX_to_ME_Valid = 1'b1;
        EX_to_ME_Bus = mk_bus(0, 0, 1, 2, 32'h0000_2000,
                              32'h2000_0002, 1, 1, 3);
        WB_Allow_in = 1'b1;
        tick();
        EX_to_ME_Valid = 1'b0;
        data_sram_rdata = 32'h8001_7FFF;
        @(negedge clk);
        res = ME_to_WB_Bus[37:6];
        n_cmp++; if (res !== 32'h0000_8001) begin n_bad++;
            $display("FAIL ldhu_result: got %h want 00008001", res); end
        n_cmp++; if (ME_dest !== 5'd3) begin n_bad++;
            $display("FAIL ldhu_dest: got %0d want 3", ME_dest); end
        tick();
    endtask

    task automatic test_stall_word();
        logic [31:0] res;
        EX_to_ME_Valid = 1'b1;
        EX_to_ME_Bus = mk_bus(0, 0, 0, 0, 32'h0000_3000,
                              32'h3000_0000, 1, 1, 4);
        WB_Allow_in = 1'b0;
        tick();
        // a second load waits in EX for the whole stall
        EX_to_ME_Bus = mk_bus(0, 0, 0, 0, 32'h0000_3004,
                              32'h3000_0004, 1, 1, 6);
        data_sram_rdata = 32'h1234_5678;
        for (int c = 0; c < 3; c++) begin
            if (c > 0) begin
                tick();
                data_sram_rdata = 32'hDEAD_BEEF;
            end
            @(negedge clk);
            res = ME_to_WB_Bus[37:6];
            n_cmp++; if (ME_Allow_in !== 1'b0) begin n_bad++;
                $display("FAIL stall_allow c%0d: got %b want 0", c, ME_Allow_in); end
            n_cmp++; if (res !== 32'h1234_5678) begin n_bad++;
                $display("FAIL stall_result c%0d: got %h want 12345678", c, res); end
            n_cmp++; if (ME_to_WB_Bus[69:38] !== 32'h0000_3000) begin n_bad++;
                $display("FAIL stall_pc c%0d: got %h", c, ME_to_WB_Bus[69:38]); end
        end
        tick();
        WB_Allow_in = 1'b1;
        @(negedge clk);
        res = ME_to_WB_Bus[37:6];
        n_cmp++; if (res !== 32'h1234_5678) begin n_bad++;
            $display("FAIL stall_handoff: got %h want 12345678", res); end
        n_cmp++; if (ME_Allow_in !== 1'b1) begin n_bad++;
            $display("FAIL stall_release: got %b want 1", ME_Allow_in); end
        tick();
        EX_to_ME_Valid = 1'b0;
        data_sram_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        res = ME_to_WB_Bus[37:6];
        n_cmp++; if (res !== 32'hCAFE_F00D) begin n_bad++;
            $display("FAIL stall_next_live: got %h want cafef00d", res); end
        n_cmp++; if (ME_to_WB_Bus[69:38] !== 32'h0000_3004) begin n_bad++;
            $display("FAIL stall_next_pc: got %h", ME_to_WB_Bus[69:38]); end
        tick();
    endtask

    task automatic test_alu();
        EX_to_ME_Valid = 1'b1;
        EX_to_ME_Bus = mk_bus(0, 0, 0, 0, 32'h0000_4000,
                              32'h0000_0042, 0, 1, 5);
        WB_Allow_in = 1'b1;
        tick();
        EX_to_ME_Valid = 1'b0;
        data_sram_rdata = $urandom;
        @(negedge clk);
        n_cmp++; if (ME_to_WB_Bus[37:6] !== 32'h42) begin n_bad++;
            $display("FAIL alu_result: got %h want 42", ME_to_WB_Bus[37:6]); end
        n_cmp++; if (ME_dest !== 5'd5) begin n_bad++;
            $display("FAIL alu_dest: got %0d want 5", ME_dest); end
        n_cmp++; if (ME_to_ID_Ld_op !== 1'b0) begin n_bad++;
            $display("FAIL alu_ldop: got %b want 0", ME_to_ID_Ld_op); end
        n_cmp++; if (ME_to_WB_Bus[5:0] !== 6'b1_00101) begin n_bad++;
            $display("FAIL alu_we_dest: got %b want 100101", ME_to_WB_Bus[5:0]); end
        n_cmp++; if (ME_Forward_Res !== 32'h42) begin n_bad++;
            $display("FAIL alu_fwd: got %h want 42", ME_Forward_Res); end
        tick();
        @(negedge clk);
        n_cmp++; if (ME_dest !== 5'd0) begin n_bad++;
            $display("FAIL alu_dest_gate: got %0d want 0", ME_dest); end
        tick();
    endtask

    task automatic test_reset_mid_stall();
        EX_to_ME_Valid = 1'b1;
        EX_to_ME_Bus = mk_bus(0, 0, 0, 0, 32'h0000_5000,
                              32'h5000_0000, 1, 1, 8);
        WB_Allow_in = 1'b0;
        tick();
        EX_to_ME_Valid = 1'b0;
        data_sram_rdata = 32'hAAAA_5555;
        tick();
        data_sram_rdata = 32'h0;
        #2 resetn = 1'b0;
        #1;
        n_cmp++; if (ME_to_WB_Valid !== 1'b0) begin n_bad++;
            $display("FAIL rstmid_valid: got %b want 0", ME_to_WB_Valid); end
        n_cmp++; if (ME_Allow_in !== 1'b1) begin n_bad++;
            $display("FAIL rstmid_allow: got %b want 1", ME_Allow_in); end
        n_cmp++; if (ME_to_WB_Bus !== 70'h0) begin n_bad++;
            $display("FAIL rstmid_bus: got %h want 0", ME_to_WB_Bus); end
        @(negedge clk);
        resetn = 1'b1;
        tick();
        EX_to_ME_Valid = 1'b1;
        EX_to_ME_Bus = mk_bus(0, 1, 0, 1, 32'h0000_6000,
                              32'h6000_0001, 1, 1, 2);
        WB_Allow_in = 1'b0;
        tick();
        EX_to_ME_Valid = 1'b0;
        data_sram_rdata = 32'h0000_7700;
        @(negedge clk);
        n_cmp++; if (ME_to_WB_Bus[37:6] !== 32'h77) begin n_bad++;
            $display("FAIL rstmid_live: got %h want 77", ME_to_WB_Bus[37:6]); end
        tick();
        data_sram_rdata = 32'hFFFF_FFFF;
        WB_Allow_in = 1'b1;
        @(negedge clk);
        n_cmp++; if (ME_to_WB_Bus[37:6] !== 32'h77) begin n_bad++;
            $display("FAIL rstmid_held: got %h want 77", ME_to_WB_Bus[37:6]); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] words [4];
        bit          sg [4];
        bit          by [4];
        bit          hf [4];
        int          ad [4];
        logic [31:0] exp;
        sg = '{0, 1, 1, 0};
        by = '{0, 1, 0, 1};
        hf = '{0, 0, 1, 0};
        ad = '{0, 1, 2, 0};
        for (int k = 0; k < 4; k++) words[k] = $urandom;
        for (int k = 0; k <= 4; k++) begin
            WB_Allow_in = 1'b1;
            EX_to_ME_Valid = (k < 4);
            if (k < 4)
                EX_to_ME_Bus = mk_bus(sg[k], by[k], hf[k], 2'(ad[k]),
                                      32'h7000 + 32'(4 * k),
                                      32'h7000_0000 + 32'(ad[k]),
                                      1, 1, 5'(10 + k));
            data_sram_rdata = (k > 0) ? words[k-1] : $urandom;
            @(negedge clk);
            if (k > 0) begin
                exp = ref_align(words[k-1], sg[k-1], by[k-1],
                                hf[k-1], ad[k-1]);
                n_cmp++; if (ME_to_WB_Valid !== 1'b1) begin n_bad++;
                    $display("FAIL b2b_valid k%0d: got %b want 1", k, ME_to_WB_Valid); end
                n_cmp++; if (ME_to_WB_Bus[37:6] !== exp) begin n_bad++;
                    $display("FAIL b2b_result k%0d: got %h want %h", k, ME_to_WB_Bus[37:6], exp); end
                n_cmp++; if (ME_Allow_in !== 1'b1) begin n_bad++;
                    $display("FAIL b2b_allow k%0d: got %b want 1", k, ME_Allow_in); end
                n_cmp++; if (ME_to_ID_Ld_op !== !FWD) begin n_bad++;
                    $display("FAIL b2b_ldop k%0d: got %b want %b", k, ME_to_ID_Ld_op, !FWD); end
            end
            tick();
        end
        EX_to_ME_Valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (ME_to_WB_Valid !== 1'b0) begin n_bad++;
            $display("FAIL b2b_drain: got %b want 0", ME_to_WB_Valid); end
        tick();
    endtask

    task automatic test_random();
        bit          occ = 0;
        bit          first = 0;
        logic [75:0] r_bus = '0;
        logic [31:0] r_word = '0;
        logic [31:0] exp_res;
        bit          exv;
        bit          acc;
        int          kind;
        for (int cyc = 0; cyc < 400; cyc++) begin
            WB_Allow_in = ($urandom_range(0, 3) != 0);
            exv = $urandom_range(0, 1);
            kind = $urandom_range(0, 2);
            EX_to_ME_Valid = exv;
            EX_to_ME_Bus = mk_bus($urandom_range(0, 1), kind == 1,
                                  kind == 2, 2'($urandom_range(0, 3)),
                                  $urandom, $urandom,
                                  $urandom_range(0, 1),
                                  $urandom_range(0, 1),
                                  5'($urandom_range(0, 31)));
            data_sram_rdata = $urandom;
            if (occ && first) r_word = data_sram_rdata;
            @(negedge clk);
            n_cmp++; if (ME_to_WB_Valid !== occ) begin n_bad++;
                $display("FAIL rnd_valid c%0d: got %b want %b", cyc, ME_to_WB_Valid, occ); end
            n_cmp++; if (ME_Allow_in !== (!occ || WB_Allow_in)) begin n_bad++;
                $display("FAIL rnd_allow c%0d: got %b", cyc, ME_Allow_in); end
            if (occ) begin
                exp_res = r_bus[6] ? ref_align(r_word, r_bus[75], r_bus[74],
                                               r_bus[73], int'(r_bus[72:71]))
                                   : r_bus[38:7];
                n_cmp++; if (ME_to_WB_Bus !== {r_bus[70:39], exp_res, r_bus[5:0]}) begin n_bad++;
                    $display("FAIL rnd_bus c%0d: got %h want %h", cyc, ME_to_WB_Bus, {r_bus[70:39], exp_res, r_bus[5:0]}); end
                n_cmp++; if (ME_dest !== r_bus[4:0]) begin n_bad++;
                    $display("FAIL rnd_dest c%0d: got %0d want %0d", cyc, ME_dest, r_bus[4:0]); end
                n_cmp++; if (ME_to_ID_Ld_op !== (!FWD && r_bus[6])) begin n_bad++;
                    $display("FAIL rnd_ldop c%0d: got %b", cyc, ME_to_ID_Ld_op); end
                n_cmp++; if (ME_Forward_Res !== (FWD ? exp_res : r_bus[38:7])) begin n_bad++;
                    $display("FAIL rnd_fwd c%0d: got %h", cyc, ME_Forward_Res); end
            end else begin
                n_cmp++; if (ME_dest !== 5'd0) begin n_bad++;
                    $display("FAIL rnd_dest_idle c%0d: got %0d want 0", cyc, ME_dest); end
                n_cmp++; if (ME_to_ID_Ld_op !== 1'b0) begin n_bad++;
                    $display("FAIL rnd_ldop_idle c%0d: got %b want 0", cyc, ME_to_ID_Ld_op); end
            end
            acc = (!occ || WB_Allow_in) && exv;
            if (occ && WB_Allow_in) occ = 0;
            first = 0;
            if (acc) begin
                occ = 1;
                first = 1;
                r_bus = EX_to_ME_Bus;
            end
            tick();
        end
    endtask

    initial begin
        resetn = 1'b0;
        EX_to_ME_Valid = 1'b0;
        EX_to_ME_Bus = '0;
        WB_Allow_in = 1'b0;
        data_sram_rdata = '0;
        test_reset();
        test_ld_b_signed();
        test_ld_hu();
        test_stall_word();
        test_alu();
        test_reset_mid_stall();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/me_unit.md
ME_UNIT -- requirements
Module: me_unit

Interface
REQ-001 The block SHALL have no parameters; bus widths are fixed constants from the shared package.
REQ-002 clk  input  1  single clock; all state updates on posedge.
REQ-003 resetn  input  1  reset, asynchronous, active-low.
REQ-004 EX_to_ME_Valid  input  1  EX holds a valid instruction for ME.
REQ-005 EX_to_ME_Bus  input  76  {dest_flag[75:71]={signed,byte,half,addr[1:0]}, pc[70:39], alu_result[38:7], res_from_mem[6], gr_we[5], dest[4:0]}.
REQ-006 ME_Allow_in  output  1  ME can accept from EX this cycle.
REQ-007 data_sram_rdata  input  32  sync data SRAM read data, valid the cycle after the EX request.
REQ-008 WB_Allow_in  input  1  WB can accept from ME.
REQ-009 ME_to_WB_Valid  output  1  ME presents a valid instruction to WB.
REQ-010 ME_to_WB_Bus  output  70  {pc[69:38], final_result[37:6], gr_we[5], dest[4:0]}.
REQ-011 ME_dest  output  5  dest gated by ME_Valid, for ID hazard check.
REQ-012 ME_Forward_Res  output  32  forwarding value to ID.
REQ-013 ME_to_ID_Ld_op  output  1  ME holds a load whose data is not forwardable.

Function
REQ-014 Handshake: ME_Allow_in = !ME_Valid || WB_Allow_in; ready-go is constant 1; ME_to_WB_Valid = ME_Valid.
REQ-015 ME_Valid SHALL load EX_to_ME_Valid when ME_Allow_in, else hold.
REQ-016 Payload register SHALL capture EX_to_ME_Bus only when ME_Allow_in && EX_to_ME_Valid; otherwise hold.
REQ-017 Load alignment: byte selects rdata[8*addr[1:0]+:8]; half selects rdata[15:0] (addr[1]=0) or [31:16] (addr[1]=1); neither selects full word; signed=1 sign-extends, signed=0 zero-extends.
REQ-018 final_result = aligned load data when res_from_mem, else alu_result; combinational, zero added latency.
REQ-019 Hold buffer: one 32-bit register plus hold_vld flag; in the first cycle of occupancy, if ME_Valid && !WB_Allow_in, SHALL capture data_sram_rdata and set hold_vld.
REQ-020 While hold_vld=1 the alignment source SHALL be the hold register, not data_sram_rdata.
REQ-021 hold_vld SHALL clear on the cycle ME hands off to WB or accepts a new instruction; simultaneous hand-off and accept SHALL clear it and select live rdata for the new instruction.
REQ-022 Back-to-back loads with WB_Allow_in=1 every cycle SHALL sustain one load per cycle with no bubbles.
REQ-023 ME_dest = dest & {5{ME_Valid}}.

Reset
REQ-024 resetn low SHALL asynchronously clear ME_Valid, hold_vld, payload and hold registers to 0; outputs: ME_to_WB_Valid=0, ME_dest=0, ME_to_ID_Ld_op=0, ME_to_WB_Bus=0, ME_Forward_Res=0, ME_Allow_in=1.
REQ-025 Reset asserted mid-stall SHALL discard the in-flight instruction and held data; first instruction after deassert SHALL behave as fresh.

Configuration
REQ-026 ME_LOAD_FWD_EN defined: ME_Forward_Res = final_result; ME_to_ID_Ld_op = 0.
REQ-027 ME_LOAD_FWD_EN undefined: ME_Forward_Res = alu_result; ME_to_ID_Ld_op = ME_Valid && res_from_mem, so ID stalls the dependent instruction.

Structure
REQ-028 Shared package pipe_bus_pkg SHALL hold EX_ME/ME_WB bus widths, field offsets and dest_flag bit positions.
REQ-029 Alignment/extension SHALL be sub-module load_align (combinational: rdata, dest_flag -> 32-bit result).

Verification
REQ-030 ld.b signed, addr[1:0]=3, rdata=0x80FF_1234 -> final_result=0xFFFF_FF80.
REQ-031 ld.hu, addr[1:0]=2, rdata=0x8001_7FFF -> final_result=0x0000_8001.
REQ-032 ld.w, WB_Allow_in=0 for 3 cycles, rdata changes to 0xDEAD_BEEF after cycle 1 -> WB receives original 0x1234_5678, ME_Allow_in=0 throughout stall.
REQ-033 Non-load add, alu_result=0x0000_0042, dest=5 -> ME_to_WB_Bus result 0x42, ME_dest=5, ME_to_ID_Ld_op=0.
REQ-034 resetn pulsed low during stalled ld.w -> ME_to_WB_Valid=0 immediately, hold_vld=0, next load uses live rdata.
REQ-035 Four back-to-back loads, WB_Allow_in=1 -> four ME_to_WB_Valid cycles consecutively; with ME_LOAD_FWD_EN undefined ME_to_ID_Ld_op=1 each cycle.
